sensor_frame_encoder: RTL and testbench
=======================================

// Module: sensor_frame_encoder
// PURPOSE
//   Parametrised telemetry framer between the sensor front-ends (DHT11, PCF8591 ADC, ...) and the ESP8266 uart_tx.
//   Snapshots NUM_CH binary channel values, converts each to fixed-width ASCII decimal with a serial double-dabble.
//   Streams one text frame per trigger over a valid/ready byte interface, e.g. "T:25.3,H:067,S:008\r\n".
//   Triggers: internal period timer or an explicit request; a trigger arriving mid-frame is pended, not lost.
// PARAMETERS
//   NUM_CH      3           number of channels, 1..8
//   VAL_W       8           channel value width in bits, 4..16
//   DIGITS      3           ASCII digits per channel, 1..5; leading zeros are kept
//   PERIOD_CYC  50000000    clk cycles between periodic triggers (1 s at 50 MHz); must be >= 2
// PORTS
//   clk          in   1              system clock
//   rst_n        in   1              reset, asynchronous assert, active-low
//   en           in   1              enables the periodic timer
//   send_req     in   1              one-cycle pulse; requests a frame regardless of en
//   ch_val       in   NUM_CH*VAL_W   channel values; ch i at [i*VAL_W +: VAL_W]
//   ch_tag       in   NUM_CH*8       ASCII tag char per channel; ch i at [i*8 +: 8]
//   dp_en        in   NUM_CH         1 = insert '.' before the last digit of ch i
//   tx_ready     in   1              sink can take a byte (uart_tx not busy)
//   tx_data      out  8              frame byte
//   tx_valid     out  1              tx_data is valid
//   busy         out  1              frame in progress (any state but IDLE)
//   frame_done   out  1              one-cycle pulse, same cycle as the accepted LF byte
//   ovf_flags    out  NUM_CH         ch i was saturated in the last frame
//   overrun_cnt  out  8              saturating count of triggers dropped by the pend logic
// BEHAVIOUR
//   Reset (async): state IDLE, timer 0, pending 0.
//     All outputs 0: tx_data=8'h00, tx_valid, busy, frame_done, ovf_flags, overrun_cnt.
//   Timer: increments while en=1; at PERIOD_CYC-1 it wraps to 0 and raises tick for one cycle.
//     en=0 holds the timer at 0. en=0 neither affects a frame in progress nor clears pending.
//   Trigger = tick | send_req | pending.
//     In IDLE, a trigger moves to LATCH on the next edge.
//     In any other state, tick or send_req sets pending. If pending is already 1, overrun_cnt+1 instead (saturates at 255).
//     tick and send_req in the same cycle count as one trigger.
//   States and transitions:
//     IDLE -> LATCH.
//     LATCH: copy ch_val, ch_tag and dp_en into snapshot registers; clear pending and ovf_flags; ch=0.
//       Inputs may change freely after this point.
//     CONV: VAL_W cycles of shift-add-3 on the snapshot of ch.
//       If the value > 10^DIGITS-1, the result is forced to all 9s and ovf_flags[ch] is set.
//     EMIT: drive bytes in order: tag, ':', DIGITS digits (MSD first, 8'h30+d), with '.' before the last digit if dp_en[ch].
//       Then ',' if ch<NUM_CH-1, otherwise CR (8'h0D) and LF (8'h0A).
//       After the ',' byte: ch+1, return to CONV. After LF: go to IDLE.
//   Handshake:
//     A byte transfers on a cycle with tx_valid & tx_ready. The next byte appears the following cycle, so back-to-back is allowed.
//     While tx_valid=1 and tx_ready=0, tx_data is held stable and tx_valid stays 1.
//     tx_valid is 0 in IDLE, LATCH and CONV.
//   Latency:
//     A trigger in IDLE at cycle k gives the first tx_valid at cycle k+VAL_W+2.
//     Each channel boundary inserts a VAL_W-cycle gap with tx_valid=0.
//   Frame length: NUM_CH*(DIGITS+2) + popcount(dp_en) + (NUM_CH-1) + 2 bytes.
//   Reset asserted mid-frame aborts immediately: tx_valid drops asynchronously and no partial frame resumes.
// TESTING
//   Defaults, tags "T","H","S", ch_val=253,67,8, dp_en=3'b001, tx_ready=1, send_req pulse:
//     -> exactly 20 bytes "T:25.3,H:067,S:008\r\n"; frame_done on the LF; ovf_flags=0.
//   DIGITS=2, ch0=150, ch1=99:
//     -> ch0 digits "99" with ovf_flags[0]=1; ch1 "99" with ovf_flags[1]=0.
//   tx_ready low for 100 cycles while tx_valid=1 on the '.' byte:
//     -> tx_data stays 8'h2E, nothing dropped or duplicated, frame completes intact.
//   Three send_req pulses during a frame:
//     -> exactly one extra frame follows immediately; overrun_cnt=2.
//   PERIOD_CYC=1000, en=1:
//     -> frames start every 1000 cycles.
//     en cleared mid-frame -> current frame finishes, no further frames.
//   rst_n low during the 2nd channel's digits:
//     -> tx_valid=0 and busy=0 at once.
//     Next send_req -> complete frame starting with the ch0 tag.

Source files
------------

// File: rtl/sensor_frame_encoder.sv
// Telemetry framer: snapshots NUM_CH channel values, converts each to fixed-width
// ASCII decimal with a serial double-dabble and streams "tag:digits,...\r\n" frames.
module sensor_frame_encoder #(
    parameter int NUM_CH     = 3,
    parameter int VAL_W      = 8,
    parameter int DIGITS     = 3,
    parameter int PERIOD_CYC = 50000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    send_req,
    input  logic [NUM_CH*VAL_W-1:0] ch_val,
    input  logic [NUM_CH*8-1:0]     ch_tag,
    input  logic [NUM_CH-1:0]       dp_en,
    input  logic                    tx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    output logic                    busy,
    output logic                    frame_done,
    output logic [NUM_CH-1:0]       ovf_flags,
    output logic [7:0]              overrun_cnt
);

    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW   = $clog2(PERIOD_CYC);
    localparam int CNTW = $clog2(VAL_W);
    localparam int BW   = 4 * DIGITS;
    localparam logic [TW-1:0] TIMER_MAX = TW'(PERIOD_CYC - 1);
    localparam logic [31:0]   MAX_VAL   = 32'(10 ** DIGITS - 1);
    localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_CONV, S_EMIT} state_t;

    state_t                    state_q, state_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic                      pending_q, pending_d;
    logic [7:0]                overrun_q, overrun_d;
    logic [NUM_CH-1:0]         ovf_q, ovf_d;
    logic [CHW-1:0]            ch_q, ch_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;
    logic [3:0]                pos_q, pos_d;
    logic [VAL_W-1:0]          shr_q, shr_d;
    logic [BW-1:0]             bcd_q, bcd_d;
    logic [NUM_CH*VAL_W-1:0]   snap_val_q, snap_val_d;
    logic [NUM_CH*8-1:0]       snap_tag_q, snap_tag_d;
    logic [NUM_CH-1:0]         snap_dp_q, snap_dp_d;

    logic             tick, trig_ev, last_ch, cur_dp, cur_ovf;
    logic [VAL_W-1:0] cur_val, next_val;
    logic [7:0]       cur_tag, emit_byte;
    logic [CHW-1:0]   ch_nx;
    logic [BW-1:0]    bcd_adj, bcd_shift;
    logic             sep_pos, lf_pos;
    logic [3:0]       digit;
    int               p, ndig, dig_idx;

    assign tick     = en && (timer_q == TIMER_MAX);
    assign timer_d  = (!en || tick) ? '0 : timer_q + 1'b1;
    assign trig_ev  = tick || send_req;
    assign ch_nx    = ch_q + 1'b1;
    assign cur_val  = VAL_W'(snap_val_q >> (VAL_W * ch_q));
    assign next_val = VAL_W'(snap_val_q >> (VAL_W * ch_nx));
    assign cur_tag  = 8'(snap_tag_q >> (8 * ch_q));
    assign cur_dp   = snap_dp_q[ch_q];
    assign last_ch  = (ch_q == CHW'(NUM_CH - 1));
    assign cur_ovf  = 32'(cur_val) > MAX_VAL;

    // Double-dabble step: every BCD digit >= 5 gets +3 before the left shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                                     : bcd_q[gi*4 +: 4];
        end
    endgenerate
    assign bcd_shift = {bcd_adj[BW-2:0], shr_q[VAL_W-1]};

    // Byte at the current position of a channel field: tag ':' digits ['.'] sep [LF]
    always_comb begin
        emit_byte = 8'h00;
        sep_pos   = 1'b0;
        lf_pos    = 1'b0;
        digit     = 4'h0;
        p         = int'(pos_q) - 2;
        ndig      = DIGITS + (cur_dp ? 1 : 0);
        dig_idx   = 0;
        if (pos_q == 4'd0) begin
            emit_byte = cur_tag;
        end else if (pos_q == 4'd1) begin
            emit_byte = 8'h3A;
        end else if (p < ndig) begin
            if (cur_dp && p == DIGITS - 1) begin
                emit_byte = 8'h2E;
            end else begin
                dig_idx = (cur_dp && p >= DIGITS) ? p - 1 : p;
                for (int i = 0; i < DIGITS; i++) begin
                    if (dig_idx == i) digit = bcd_q[4*(DIGITS-1-i) +: 4];
                end
                emit_byte = {4'h3, digit};
            end
        end else if (p == ndig) begin
            sep_pos   = 1'b1;
            emit_byte = last_ch ? 8'h0D : 8'h2C;
        end else begin
            lf_pos    = 1'b1;
            emit_byte = 8'h0A;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        ovf_d      = ovf_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        shr_d      = shr_q;
        bcd_d      = bcd_q;
        snap_val_d = snap_val_q;
        snap_tag_d = snap_tag_q;
        snap_dp_d  = snap_dp_q;
        // A second trigger while one is already pended is dropped and counted.
        if ((state_q == S_CONV || state_q == S_EMIT) && trig_ev) begin
            if (pending_q) overrun_d = (overrun_q == 8'hFF) ? overrun_q : overrun_q + 8'd1;
            else           pending_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (trig_ev || pending_q) state_d = S_LATCH;
            end
            S_LATCH: begin
                snap_val_d = ch_val;
                snap_tag_d = ch_tag;
                snap_dp_d  = dp_en;
                pending_d  = trig_ev;
                ovf_d      = '0;
                ch_d       = '0;
                cnt_d      = '0;
                bcd_d      = '0;
                shr_d      = ch_val[VAL_W-1:0];
                state_d    = S_CONV;
            end
            S_CONV: begin
                bcd_d = bcd_shift;
                shr_d = {shr_q[VAL_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNTW'(VAL_W - 1)) begin
                    state_d = S_EMIT;
                    pos_d   = '0;
                    if (cur_ovf) begin
                        bcd_d        = ALL_NINES;
                        ovf_d[ch_q]  = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (tx_ready) begin
                    if (sep_pos && !last_ch) begin
                        ch_d    = ch_nx;
                        cnt_d   = '0;
                        bcd_d   = '0;
                        pos_d   = '0;
                        shr_d   = next_val;
                        state_d = S_CONV;
                    end else if (lf_pos) begin
                        state_d = S_IDLE;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= '0;
            ovf_q      <= '0;
            ch_q       <= '0;
            cnt_q      <= '0;
            pos_q      <= '0;
            shr_q      <= '0;
            bcd_q      <= '0;
            snap_val_q <= '0;
            snap_tag_q <= '0;
            snap_dp_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            ovf_q      <= ovf_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
            shr_q      <= shr_d;
            bcd_q      <= bcd_d;
            snap_val_q <= snap_val_d;
            snap_tag_q <= snap_tag_d;
            snap_dp_q  <= snap_dp_d;
        end
    end

    assign tx_valid    = (state_q == S_EMIT);
    assign tx_data     = tx_valid ? emit_byte : 8'h00;
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = tx_valid && tx_ready && lf_pos;
    assign ovf_flags   = ovf_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_sensor_frame_encoder.sv
// Bench for sensor_frame_encoder: a 3-channel/3-digit instance and a 2-channel/2-digit
// instance checked against a decimal-formatting reference model and literal frames.
module tb_sensor_frame_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_en, a_req, a_ready;
    logic [23:0] a_val, a_tag;
    logic [2:0]  a_dp;
    logic [7:0]  a_data, a_ovr;
    logic        a_valid, a_busy, a_done;
    logic [2:0]  a_ovf;

    logic        b_en, b_req, b_ready;
    logic [15:0] b_val, b_tag;
    logic [1:0]  b_dp;
    logic [7:0]  b_data, b_ovr;
    logic        b_valid, b_busy, b_done;
    logic [1:0]  b_ovf;

    sensor_frame_encoder #(.NUM_CH(3), .VAL_W(8), .DIGITS(3), .PERIOD_CYC(1000)) u_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .send_req(a_req), .ch_val(a_val),
        .ch_tag(a_tag), .dp_en(a_dp), .tx_ready(a_ready), .tx_data(a_data),
        .tx_valid(a_valid), .busy(a_busy), .frame_done(a_done), .ovf_flags(a_ovf),
        .overrun_cnt(a_ovr));

    sensor_frame_encoder #(.NUM_CH(2), .VAL_W(8), .DIGITS(2), .PERIOD_CYC(1000)) u_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .send_req(b_req), .ch_val(b_val),
        .ch_tag(b_tag), .dp_en(b_dp), .tx_ready(b_ready), .tx_data(b_data),
        .tx_valid(b_valid), .busy(b_busy), .frame_done(b_done), .ovf_flags(b_ovf),
        .overrun_cnt(b_ovr));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_a[$];
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    logic [7:0] mdl_q[$];
    logic [7:0] mdl_ovf;
    logic [2:0] exp_ovf_a;
    int         rdy_mode = 0;
    int         stall_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Reference frame text from the formatting rules: saturate, print decimal, insert '.'
    function automatic void model_frame(input int nch, input int digits, input logic [63:0] tags,
                                        input logic [127:0] vals, input logic [7:0] dp);
        mdl_q.delete();
        mdl_ovf = 8'h00;
        for (int c = 0; c < nch; c++) begin
            int v;
            v = int'(vals[c*16 +: 16]);
            if (v >= pow10(digits)) begin
                v = pow10(digits) - 1;
                mdl_ovf[c] = 1'b1;
            end
            mdl_q.push_back(tags[c*8 +: 8]);
            mdl_q.push_back(8'h3A);
            for (int d = digits - 1; d >= 0; d--) begin
                if (dp[c] && d == 0) mdl_q.push_back(8'h2E);
                mdl_q.push_back(8'h30 + 8'((v / pow10(d)) % 10));
            end
            if (c < nch - 1) mdl_q.push_back(8'h2C);
            else begin
                mdl_q.push_back(8'h0D);
                mdl_q.push_back(8'h0A);
            end
        end
    endfunction

    task automatic add_exp_a();
        logic [127:0] v;
        logic [63:0]  t;
        v = '0;
        t = '0;
        for (int i = 0; i < 3; i++) begin
            v[i*16 +: 16] = {8'h00, a_val[i*8 +: 8]};
            t[i*8 +: 8]   = a_tag[i*8 +: 8];
        end
        model_frame(3, 3, t, v, {5'b0, a_dp});
        foreach (mdl_q[i]) exp_a.push_back(mdl_q[i]);
        exp_ovf_a = mdl_ovf[2:0];
    endtask

    task automatic model_b();
        logic [127:0] v;
        logic [63:0]  t;
        v = '0;
        t = '0;
        for (int i = 0; i < 2; i++) begin
            v[i*16 +: 16] = {8'h00, b_val[i*8 +: 8]};
            t[i*8 +: 8]   = b_tag[i*8 +: 8];
        end
        model_frame(2, 2, t, v, {6'b0, b_dp});
    endtask

    task automatic cmp_lit(input string nm, input string s, input bit which);
        int bad = 0;
        int n;
        logic [7:0] g;
        n = which ? got_b.size() : got_a.size();
        chk({nm, "_len"}, 32'(n), 32'(s.len()));
        for (int i = 0; i < s.len(); i++) begin
            g = 8'h00;
            if (i < n) g = which ? got_b[i] : got_a[i];
            if (g != s[i]) bad++;
        end
        chk({nm, "_bytes"}, 32'(bad), 32'd0);
    endtask

    task automatic wait_a_busy(input logic lvl, input int lim, input string nm);
        int n = 0;
        while (a_busy !== lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_busy_wait"}, 32'(a_busy), 32'(lvl));
    endtask

    task automatic wait_done(input bit which, input int lim, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(which ? b_done : a_done) && n < lim);
        chk({nm, "_done_wait"}, 32'(which ? b_done : a_done), 32'd1);
        #1;
    endtask

    task automatic pulse(input bit which);
        @(posedge clk);
        #1;
        if (which) b_req = 1'b1; else a_req = 1'b1;
        @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    // Sink model for DUT A: always ready, random ready, or a 100-cycle stall on '.'.
    initial begin
        a_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: a_ready = ($urandom_range(0, 3) != 0);
                2: if (a_valid && a_data == 8'h2E && stall_n < 100) begin
                       a_ready = 1'b0;
                       stall_n++;
                   end else a_ready = 1'b1;
                default: a_ready = 1'b1;
            endcase
        end
    end

    // Per-cycle compare of DUT A against the expected byte stream and the handshake rules.
    initial begin
        logic       pv, pr;
        logic [7:0] pd, e;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", 32'(a_valid), 32'd1);
                    chk("hold_data", 32'(a_data), 32'(pd));
                end
                if (!a_busy) chk("valid_when_idle", 32'(a_valid), 32'd0);
                if (a_valid && a_ready) begin
                    if (exp_a.size() == 0) begin
                        chk("unexpected_byte", 32'(a_data), 32'h100);
                    end else begin
                        e = exp_a.pop_front();
                        chk("byte", 32'(a_data), 32'(e));
                        chk("frame_done_on_lf", 32'(a_done), 32'(e == 8'h0A));
                        got_a.push_back(a_data);
                    end
                end else begin
                    chk("frame_done_quiet", 32'(a_done), 32'd0);
                end
                pv = a_valid; pr = a_ready; pd = a_data;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && b_valid && b_ready) got_b.push_back(b_data);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t0, t1, bad;
        string lit_a;
        lit_a = "T:25.3,H:067,S:008\r\n";
        rst_n = 1'b0; a_en = 1'b0; a_req = 1'b0; b_en = 1'b0; b_req = 1'b0; b_ready = 1'b1;
        a_val = '0; a_tag = '0; a_dp = '0; b_val = '0; b_tag = '0; b_dp = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_data", 32'(a_data), 32'd0);
        chk("rst_tx_valid", 32'(a_valid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_frame_done", 32'(a_done), 32'd0);
        chk("rst_ovf", 32'(a_ovf), 32'd0);
        chk("rst_overrun", 32'(a_ovr), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        #2 rst_n = 1'b1;

        // Directed default frame with latency and span checks
        a_tag = {8'h53, 8'h48, 8'h54};
        a_val = {8'd8, 8'd67, 8'd253};
        a_dp  = 3'b001;
        got_a.delete();
        add_exp_a();
        @(posedge clk);
        #1 a_req = 1'b1;
        @(negedge clk);
        n = 0;
        @(posedge clk);
        #1 a_req = 1'b0;
        while (!a_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("first_byte_latency", 32'(n), 32'd10);
        t0 = cyc;
        wait_done(0, 200, "directed");
        chk("frame_span_cycles", 32'(cyc - t0), 32'd35);
        cmp_lit("directed", lit_a, 0);
        chk("directed_ovf", 32'(a_ovf), 32'd0);
        $display("frame a directed bytes=%0d", got_a.size());

        // Backpressure on the '.' byte
        got_a.delete();
        add_exp_a();
        stall_n = 0;
        rdy_mode = 2;
        pulse(0);
        wait_done(0, 400, "stall");
        chk("stall_cycles", 32'(stall_n), 32'd100);
        cmp_lit("stall", lit_a, 0);
        rdy_mode = 0;
        $display("frame a stalled bytes=%0d", got_a.size());

        // Three requests during a frame: one extra frame, two drops
        got_a.delete();
        add_exp_a();
        add_exp_a();
        pulse(0);
        wait_a_busy(1'b1, 20, "overrun");
        repeat (3) begin
            repeat (4) @(posedge clk);
            pulse(0);
        end
        wait_done(0, 300, "overrun_first");
        t1 = cyc;
        wait_done(0, 300, "overrun_second");
        chk("pended_frame_gap", 32'(cyc - t1), 32'd46);
        chk("overrun_cnt", 32'(a_ovr), 32'd2);
        chk("overrun_bytes", 32'(got_a.size()), 32'd40);
        chk("overrun_queue_empty", 32'(exp_a.size()), 32'd0);
        $display("frame a overrun pair bytes=%0d overrun=%0d", got_a.size(), a_ovr);

        // Random frames, random sink, inputs scrambled after the snapshot
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 3; i++) begin
                a_val[i*8 +: 8] = 8'($urandom_range(0, 255));
                a_tag[i*8 +: 8] = 8'(8'h41 + $urandom_range(0, 25));
            end
            a_dp = 3'($urandom_range(0, 7));
            add_exp_a();
            rdy_mode = 1;
            pulse(0);
            wait_a_busy(1'b1, 20, "random");
            @(posedge clk);
            #1;
            a_val = 24'($urandom);
            a_tag = 24'($urandom);
            a_dp  = 3'($urandom);
            wait_done(0, 1000, "random");
            chk("random_ovf", 32'(a_ovf), 32'(exp_ovf_a));
            chk("random_queue_empty", 32'(exp_a.size()), 32'd0);
            $display("frame a random #%0d dp=%b", it, a_dp);
        end
        rdy_mode = 0;

        // Periodic trigger, then en cleared mid-frame
        for (int i = 0; i < 3; i++) a_val[i*8 +: 8] = 8'($urandom_range(0, 255));
        a_tag = {8'h53, 8'h48, 8'h54};
        a_dp = 3'b010;
        add_exp_a(); add_exp_a(); add_exp_a();
        @(posedge clk);
        #1 a_en = 1'b1;
        wait_a_busy(1'b1, 1100, "period1");
        t0 = cyc;
        wait_a_busy(1'b0, 200, "period1_end");
        wait_a_busy(1'b1, 1100, "period2");
        chk("period_interval1", 32'(cyc - t0), 32'd1000);
        t0 = cyc;
        wait_a_busy(1'b0, 200, "period2_end");
        wait_a_busy(1'b1, 1100, "period3");
        chk("period_interval2", 32'(cyc - t0), 32'd1000);
        repeat (15) @(negedge clk);
        a_en = 1'b0;
        wait_a_busy(1'b0, 200, "period3_end");
        bad = 0;
        repeat (2500) begin
            @(negedge clk);
            if (a_busy) bad++;
        end
        chk("no_frame_after_en_low", 32'(bad), 32'd0);
        chk("period_queue_empty", 32'(exp_a.size()), 32'd0);
        $display("frame a periodic three frames done");

        // Reset in the middle of the second channel's digits
        a_tag = {8'h53, 8'h48, 8'h54};
        a_val = {8'd8, 8'd67, 8'd253};
        a_dp  = 3'b001;
        got_a.delete();
        add_exp_a();
        pulse(0);
        n = 0;
        while (got_a.size() < 9 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #1;
        chk("mid_digit_valid", 32'(a_valid), 32'd1);
        chk("mid_digit_data", 32'(a_data), 32'h30);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(a_valid), 32'd0);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_data", 32'(a_data), 32'd0);
        exp_a.delete();
        got_a.delete();
        repeat (3) @(negedge clk);
        chk("abort_overrun_cleared", 32'(a_ovr), 32'd0);
        #2 rst_n = 1'b1;
        add_exp_a();
        pulse(0);
        wait_done(0, 200, "after_reset");
        cmp_lit("after_reset", lit_a, 0);
        chk("after_reset_first_tag", 32'(got_a.size() > 0 ? got_a[0] : 8'h00), 32'h54);
        $display("frame a after reset bytes=%0d", got_a.size());

        // Two-digit instance: saturation
        b_tag = {8'h42, 8'h41};
        b_val = {8'd99, 8'd150};
        b_dp  = 2'b00;
        got_b.delete();
        pulse(1);
        wait_done(1, 200, "b_sat");
        cmp_lit("b_sat", "A:99,B:99\r\n", 1);
        chk("b_sat_ovf", 32'(b_ovf), 32'd1);
        $display("frame b saturation ovf=%b", b_ovf);

        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < 2; i++) begin
                b_val[i*8 +: 8] = 8'($urandom_range(0, 255));
                b_tag[i*8 +: 8] = 8'(8'h61 + $urandom_range(0, 25));
            end
            b_dp = 2'($urandom_range(0, 3));
            model_b();
            got_b.delete();
            pulse(1);
            wait_done(1, 200, "b_random");
            chk("b_random_len", 32'(got_b.size()), 32'(mdl_q.size()));
            bad = 0;
            for (int i = 0; i < mdl_q.size(); i++)
                if (i >= got_b.size() || got_b[i] != mdl_q[i]) bad++;
            chk("b_random_bytes", 32'(bad), 32'd0);
            chk("b_random_ovf", 32'(b_ovf), 32'(mdl_ovf[1:0]));
            $display("frame b random #%0d vals=%0d,%0d", it, b_val[7:0], b_val[15:8]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
